y86_fetch: RTL and testbench
============================

# y86_fetch

Sequential instruction-fetch stage for the Y86-64 processor, sitting upstream of decode and acting as the consumer of the next-PC value produced by the PC-update stage. It holds the architectural PC and reads an instruction byte-serially from a byte-wide instruction memory over a req/ack handshake. It assembles icode/ifun, register IDs and the little-endian 8-byte constant, computes valP, and presents the result to decode over a valid/ready handshake. It then waits for the next PC to be loaded back from PC update.

## Interface
Parameters:
- RESET_PC, 64'd0, PC value loaded on reset.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- pcnxt  input  64  next PC from PC update.
- pc_load  input  1  pcnxt is valid this cycle.
- mem_req  output  1  byte read request.
- mem_addr  output  64  byte address; stable while mem_req=1 and mem_ack=0.
- mem_ack  input  1  mem_rdata/mem_err valid this cycle; may be asserted in the same cycle as mem_req.
- mem_rdata  input  8  read byte.
- mem_err  input  1  address invalid; qualified by mem_ack.
- out_valid  output  1  fetched instruction available.
- out_ready  input  1  decode accepts.
- icode, ifun  output  4 each  opcode fields.
- rA, rB  output  4 each  register IDs; 4'hF when the instruction has none.
- valC  output  64  constant; 0 when the instruction has none.
- valP  output  64  PC + instruction length.
- pc  output  64  PC of the instruction on the outputs.
- instr_err  output  1  icode > 4'hB.
- imem_err  output  1  memory error during fetch.

## Operation
- States: FETCH_OP, FETCH_REG, FETCH_CONST, DONE, WAIT_PC, HALTED.
- Reset values: state=FETCH_OP, pc=RESET_PC, all other outputs 0, rA=rB=4'hF.
- mem_req=1 exactly in the FETCH_* states. mem_addr = pc + byte_cnt. A byte is consumed in every cycle with mem_ack=1.
- FETCH_OP: the byte sets {icode, ifun}. Instruction lengths:
  - 1 byte: 0 (halt), 1 (nop), 9 (ret).
  - 2 bytes: 2, 6, A, B.
  - 9 bytes: 7, 8 (no register byte).
  - 10 bytes: 3, 4, 5.
  - icode > B: length 1, instr_err=1.
- Next state after FETCH_OP: FETCH_REG if the instruction has a register byte, else FETCH_CONST if it has valC, else DONE.
- FETCH_REG: the byte sets {rA, rB} (high nibble is rA). Next is FETCH_CONST or DONE.
- FETCH_CONST: 8 bytes; byte k goes to valC[8k+7:8k]. A 3-bit counter tracks k; go to DONE after k=7.
- Memory error: mem_ack=1 with mem_err=1 in any FETCH_* state → DONE with imem_err=1 and valP=pc. Fields already captured are kept.
- DONE: out_valid=1 and all outputs are held stable. On out_valid&out_ready:
  - icode=0, instr_err or imem_err → HALTED.
  - Otherwise, if pc_load is high in the same cycle → pc<=pcnxt and go to FETCH_OP.
  - Otherwise → WAIT_PC.
- WAIT_PC: out_valid=0. On pc_load, pc<=pcnxt, clear the fields (rA=rB=F, valC=0, errors=0), then go to FETCH_OP.
- pc_load in FETCH_*, in DONE without a handshake, or in HALTED is ignored.
- HALTED: mem_req=0, out_valid=0, outputs hold the last instruction. Only rst exits this state.
- valP arithmetic is modulo 2^64; wrap-around is silent.
- mem_addr wraps modulo 2^64 across the bytes of one instruction.

## Timing
- With mem_ack tied to 1, an N-byte instruction takes N FETCH cycles, and out_valid rises on the next cycle. For example, irmovq: 10 fetch cycles, then out_valid at cycle 11.
- Each memory wait cycle adds one cycle. mem_addr only advances on the edge after an ack.
- Best-case throughput: one N-byte instruction per N+1 cycles, when pc_load arrives together with the handshake.
- rst has priority over everything in any state. A memory transaction in flight at reset is abandoned: mem_req=0 for the reset cycle, and any later ack from it is unsupported.

## Structure
- Package y86_pkg holds:
  - icode localparams (I_HALT…I_POPQ).
  - the fetch state enum.
  - the REG_NONE=4'hF constant.
- One combinational sub-module, y86_instr_len: icode → {len[3:0], need_regids, need_valC, instr_err}. The FSM and PC register live in y86_fetch.

## Test plan
- Reset with RESET_PC=0, memory holding 30 F2 08 07 06 05 04 03 02 01 at address 0, mem_ack=1 → out_valid at cycle 11 with icode=3, rA=F, rB=2, valC=64'h0102030405060708, valP=10.
- jXX 73 at address 0x40 followed by 8-byte target 0x100, loaded via pc_load and pcnxt=0x40 → rA=rB=F, valC=0x100, valP=0x49, 9 fetch cycles.
- ret (90) with mem_ack delayed 3 cycles per byte and out_ready=0 for 5 cycles → outputs stable throughout; handshake, then WAIT_PC; pc_load with pcnxt=0x200 → fetch resumes at 0x200.
- Byte 0x00 (halt) → out_valid with icode=0, valP=pc+1, then HALTED: mem_req stays 0, pc_load ignored; after rst, fetch restarts at RESET_PC.
- Invalid byte C0 → instr_err=1, valP=pc+1, then HALTED. Separately, mem_err on the third byte of rmmovq → imem_err=1, valP=pc.
- pc_load asserted in the handshake cycle, with pcnxt=0x300 and instruction 10 (nop) at 0x300 → WAIT_PC is skipped and mem_addr=0x300 on the next cycle.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared definitions for the Y86-64 fetch stage: opcodes, FSM states, register sentinel.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [2:0] {
    FETCH_OP,
    FETCH_REG,
    FETCH_CONST,
    DONE,
    WAIT_PC,
    HALTED
  } fetch_state_t;

endpackage

// File: rtl/y86_instr_len.sv
// Opcode classifier: instruction length and which optional fields follow the opcode byte.
module y86_instr_len
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  output logic [3:0] len,
  output logic       need_regids,
  output logic       need_valC,
  output logic       instr_err
);

  // Pure lookup on the opcode nibble; unknown opcodes are one byte long and flagged.
  always_comb begin
    len         = 4'd1;
    need_regids = 1'b0;
    need_valC   = 1'b0;
    instr_err   = 1'b0;
    case (icode)
      I_HALT, I_NOP, I_RET: len = 4'd1;
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
        len         = 4'd2;
        need_regids = 1'b1;
      end
      I_JXX, I_CALL: begin
        len       = 4'd9;
        need_valC = 1'b1;
      end
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
        len         = 4'd10;
        need_regids = 1'b1;
        need_valC   = 1'b1;
      end
      default: instr_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/y86_fetch.sv
// Byte-serial Y86-64 fetch stage: walks an instruction out of byte memory, hands it
// to decode, then waits for the next PC from the PC-update stage.
module y86_fetch
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] pcnxt,
  input  logic        pc_load,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic [63:0] pc,
  output logic        instr_err,
  output logic        imem_err
);

  fetch_state_t state;
  logic [3:0]   byte_cnt;
  logic [2:0]   const_idx;

  logic [3:0]   cls_icode;
  logic [3:0]   il_len;
  logic         il_need_reg;
  logic         il_need_c;
  logic         il_err;

  // While the opcode byte is arriving classify it directly; afterwards use the captured opcode.
  assign cls_icode = (state == FETCH_OP) ? mem_rdata[7:4] : icode;

  y86_instr_len u_len (
    .icode       (cls_icode),
    .len         (il_len),
    .need_regids (il_need_reg),
    .need_valC   (il_need_c),
    .instr_err   (il_err)
  );

  // Request is dropped during reset so an in-flight read is abandoned immediately.
  assign mem_req   = !rst && (state == FETCH_OP || state == FETCH_REG || state == FETCH_CONST);
  assign mem_addr  = pc + {60'd0, byte_cnt};
  assign out_valid = (state == DONE);

  // Fetch FSM, PC register and instruction field capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH_OP;
      pc        <= RESET_PC;
      byte_cnt  <= 4'd0;
      const_idx <= 3'd0;
      icode     <= 4'd0;
      ifun      <= 4'd0;
      rA        <= REG_NONE;
      rB        <= REG_NONE;
      valC      <= 64'd0;
      valP      <= 64'd0;
      instr_err <= 1'b0;
      imem_err  <= 1'b0;
    end else begin
      case (state)
        FETCH_OP: if (mem_ack) begin
          if (mem_err) begin
            imem_err <= 1'b1;
            valP     <= pc;
            state    <= DONE;
          end else begin
            icode     <= mem_rdata[7:4];
            ifun      <= mem_rdata[3:0];
            instr_err <= il_err;
            valP      <= pc + {60'd0, il_len};
            byte_cnt  <= 4'd1;
            const_idx <= 3'd0;
            state     <= il_need_reg ? FETCH_REG : (il_need_c ? FETCH_CONST : DONE);
          end
        end
        FETCH_REG: if (mem_ack) begin
          if (mem_err) begin
            imem_err <= 1'b1;
            valP     <= pc;
            state    <= DONE;
          end else begin
            rA       <= mem_rdata[7:4];
            rB       <= mem_rdata[3:0];
            byte_cnt <= byte_cnt + 4'd1;
            state    <= il_need_c ? FETCH_CONST : DONE;
          end
        end
        FETCH_CONST: if (mem_ack) begin
          if (mem_err) begin
            imem_err <= 1'b1;
            valP     <= pc;
            state    <= DONE;
          end else begin
            valC[{const_idx, 3'b000} +: 8] <= mem_rdata;
            const_idx <= const_idx + 3'd1;
            byte_cnt  <= byte_cnt + 4'd1;
            if (const_idx == 3'd7) state <= DONE;
          end
        end
        DONE: if (out_ready) begin
          if (icode == I_HALT || instr_err || imem_err) begin
            state <= HALTED;
          end else if (pc_load) begin
            pc        <= pcnxt;
            byte_cnt  <= 4'd0;
            icode     <= 4'd0;
            ifun      <= 4'd0;
            rA        <= REG_NONE;
            rB        <= REG_NONE;
            valC      <= 64'd0;
            instr_err <= 1'b0;
            imem_err  <= 1'b0;
            state     <= FETCH_OP;
          end else begin
            state <= WAIT_PC;
          end
        end
        WAIT_PC: if (pc_load) begin
          pc        <= pcnxt;
          byte_cnt  <= 4'd0;
          icode     <= 4'd0;
          ifun      <= 4'd0;
          rA        <= REG_NONE;
          rB        <= REG_NONE;
          valC      <= 64'd0;
          instr_err <= 1'b0;
          imem_err  <= 1'b0;
          state     <= FETCH_OP;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_y86_fetch.sv
// Bench for y86_fetch: byte memory with random ack latency, instruction-level reference model.
module tb_y86_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] pcnxt = 64'd0;
  logic        pc_load = 1'b0;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = 8'd0;
  logic        mem_err = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP, pc;
  logic        instr_err, imem_err;

  always #5 clk = ~clk;

  y86_fetch #(.RESET_PC(64'd0)) dut (
    .clk(clk), .rst(rst), .pcnxt(pcnxt), .pc_load(pc_load),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .mem_err(mem_err),
    .out_valid(out_valid), .out_ready(out_ready),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
    .valC(valC), .valP(valP), .pc(pc),
    .instr_err(instr_err), .imem_err(imem_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- memory model ----------------
  logic [7:0] mem [logic [63:0]];
  localparam logic [63:0] ERR_LO = 64'h8000;
  localparam logic [63:0] ERR_HI = 64'h8010;

  function automatic bit is_err(input logic [63:0] a);
    return (a >= ERR_LO) && (a < ERR_HI);
  endfunction

  function automatic logic [7:0] rd(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return 8'h10;
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp, pc;
    bit          ierr, merr;
  } ins_t;

  function automatic void shape(input logic [3:0] ic, output int len, output bit hr, output bit hc);
    len = 1; hr = 0; hc = 0;
    if (ic inside {4'h2, 4'h6, 4'hA, 4'hB}) begin len = 2; hr = 1; end
    else if (ic inside {4'h7, 4'h8}) begin len = 9; hc = 1; end
    else if (ic inside {4'h3, 4'h4, 4'h5}) begin len = 10; hr = 1; hc = 1; end
  endfunction

  function automatic ins_t decode(input logic [63:0] p);
    ins_t r;
    int len;
    bit hr, hc;
    logic [63:0] a;
    logic [7:0] b;
    r.pc = p; r.icode = 0; r.ifun = 0; r.ra = 4'hF; r.rb = 4'hF;
    r.valc = 0; r.valp = p; r.ierr = 0; r.merr = 0;
    if (is_err(p)) begin r.merr = 1; return r; end
    b = rd(p);
    r.icode = b[7:4]; r.ifun = b[3:0]; r.ierr = (b[7:4] > 4'hB);
    shape(r.icode, len, hr, hc);
    a = p + 64'd1;
    if (hr) begin
      if (is_err(a)) begin r.merr = 1; return r; end
      b = rd(a); r.ra = b[7:4]; r.rb = b[3:0]; a = a + 64'd1;
    end
    if (hc) begin
      for (int k = 0; k < 8; k++) begin
        if (is_err(a)) begin r.merr = 1; return r; end
        r.valc[8*k +: 8] = rd(a);
        a = a + 64'd1;
      end
    end
    r.valp = p + 64'(len);
    return r;
  endfunction

  function automatic bit halts(input ins_t r);
    return (r.icode == 4'h0) || r.ierr || r.merr;
  endfunction

  task automatic put_instr(input logic [63:0] a, input logic [3:0] ic);
    int len; bit hr, hc;
    logic [63:0] p;
    shape(ic, len, hr, hc);
    mem[a] = {ic, 4'($urandom)};
    p = a + 64'd1;
    if (hr) begin mem[p] = 8'($urandom); p = p + 64'd1; end
    if (hc) for (int k = 0; k < 8; k++) begin mem[p] = 8'($urandom); p = p + 64'd1; end
  endtask

  ins_t expi;
  bit   exp_halted = 0;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, e, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  int fixed_delay = 0;
  int wl = 0;

  function automatic int pick();
    return (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 2));
  endfunction

  always @(negedge clk) begin
    if (!mem_req) begin
      mem_ack = 1'b0; mem_err = 1'($urandom); mem_rdata = 8'($urandom);
      wl = pick();
    end else if (wl == 0) begin
      mem_ack = 1'b1; mem_rdata = rd(mem_addr); mem_err = is_err(mem_addr);
      wl = pick();
    end else begin
      mem_ack = 1'b0; mem_err = 1'($urandom); mem_rdata = 8'($urandom);
      wl--;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!rst && (out_valid || exp_halted)) begin
      if (exp_halted) begin
        chk("halted mem_req", 64'(mem_req), 64'd0);
        chk("halted out_valid", 64'(out_valid), 64'd0);
      end
      chk("icode", 64'(icode), 64'(expi.icode));
      chk("ifun", 64'(ifun), 64'(expi.ifun));
      chk("rA", 64'(rA), 64'(expi.ra));
      chk("rB", 64'(rB), 64'(expi.rb));
      chk("valC", valC, expi.valc);
      chk("valP", valP, expi.valp);
      chk("pc", pc, expi.pc);
      chk("instr_err", 64'(instr_err), 64'(expi.ierr));
      chk("imem_err", 64'(imem_err), 64'(expi.merr));
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; pc_load = 1'b0; out_ready = 1'b0; exp_halted = 0;
    step(); step();
    chk("rst mem_req", 64'(mem_req), 64'd0);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst pc", pc, 64'd0);
    chk("rst rA/rB", 64'({rA, rB}), 64'hFF);
    chk("rst valC", valC, 64'd0);
    chk("rst valP", valP, 64'd0);
    chk("rst icode/ifun/errs", 64'({icode, ifun, instr_err, imem_err}), 64'd0);
    rst = 1'b0;
    expi = decode(64'd0);
    #1;
    chk("restart mem_req", 64'(mem_req), 64'd1);
    chk("restart mem_addr", mem_addr, 64'd0);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 300) begin
      pc_load = ($urandom_range(0, 3) == 0);
      pcnxt = {$urandom, $urandom};
      step();
      cyc++;
    end
    pc_load = 1'b0;
    chk("out_valid rise", 64'(out_valid), 64'd1);
  endtask

  task automatic handshake(input int hold, input bit direct, input logic [63:0] nxt, input int gap);
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0; pc_load = 1'($urandom); pcnxt = {$urandom, $urandom};
      step();
    end
    out_ready = 1'b1; pc_load = direct; pcnxt = nxt;
    step();
    out_ready = 1'b0; pc_load = 1'b0;
    if (halts(expi)) begin
      exp_halted = 1;
      for (int i = 0; i < 4; i++) begin
        pc_load = 1'b1; pcnxt = {$urandom, $urandom};
        step();
      end
      pc_load = 1'b0;
    end else begin
      if (!direct) begin
        chk("wait_pc out_valid", 64'(out_valid), 64'd0);
        for (int i = 0; i < gap; i++) step();
        pc_load = 1'b1; pcnxt = nxt;
        step();
        pc_load = 1'b0;
      end
      expi = decode(nxt);
      chk("load mem_addr", mem_addr, nxt);
      chk("load mem_req", 64'(mem_req), 64'd1);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [63:0] nxt;
    logic [3:0]  ic;
    int sel;
    logic [7:0] irm [10];
    irm = '{8'h30, 8'hF2, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    for (int i = 0; i < 10; i++) mem[64'(i)] = irm[i];
    mem[64'h40] = 8'h73; mem[64'h41] = 8'h00; mem[64'h42] = 8'h01;
    for (int i = 3; i < 9; i++) mem[64'h40 + 64'(i)] = 8'h00;
    mem[64'h100] = 8'h90;
    mem[64'h200] = 8'h10;
    mem[64'h300] = 8'h10;
    mem[64'h301] = 8'h00;
    mem[64'h500] = 8'hC0;
    mem[64'h7FFE] = 8'h40; mem[64'h7FFF] = 8'h12;

    // irmovq at reset PC, ack every cycle
    fixed_delay = 0;
    do_reset();
    wait_valid(cyc);
    chk("irmovq cycles", 64'(cyc), 64'd10);
    chk("irmovq icode", 64'(icode), 64'd3);
    chk("irmovq rA/rB", 64'({rA, rB}), 64'hF2);
    chk("irmovq valC", valC, 64'h0102030405060708);
    chk("irmovq valP", valP, 64'd10);
    handshake(2, 1'b0, 64'h40, 1);

    // jXX
    wait_valid(cyc);
    chk("jxx cycles", 64'(cyc), 64'd9);
    chk("jxx rA/rB", 64'({rA, rB}), 64'hFF);
    chk("jxx valC", valC, 64'h100);
    chk("jxx valP", valP, 64'h49);
    fixed_delay = 3;
    handshake(0, 1'b0, 64'h100, 0);

    // ret with slow memory, decode stalled
    wait_valid(cyc);
    chk("ret cycles", 64'(cyc), 64'd4);
    chk("ret icode", 64'(icode), 64'd9);
    chk("ret valP", valP, 64'h101);
    fixed_delay = 0;
    handshake(5, 1'b0, 64'h200, 2);

    // nop, then pc_load in the handshake cycle
    wait_valid(cyc);
    chk("nop valP", valP, 64'h201);
    handshake(0, 1'b1, 64'h300, 0);
    wait_valid(cyc);
    chk("nop2 cycles", 64'(cyc), 64'd1);
    handshake(0, 1'b1, 64'h301, 0);

    // halt
    wait_valid(cyc);
    chk("halt icode", 64'(icode), 64'd0);
    chk("halt valP", valP, 64'h302);
    handshake(1, 1'b0, 64'h999, 0);
    chk("halted pc", pc, 64'h301);

    // invalid opcode
    do_reset();
    wait_valid(cyc);
    handshake(0, 1'b1, 64'h500, 0);
    wait_valid(cyc);
    chk("inv instr_err", 64'(instr_err), 64'd1);
    chk("inv valP", valP, 64'h501);
    handshake(0, 1'b0, 64'd0, 0);

    // memory error on third byte of rmmovq
    do_reset();
    wait_valid(cyc);
    handshake(0, 1'b0, 64'h7FFE, 0);
    wait_valid(cyc);
    chk("merr cycles", 64'(cyc), 64'd3);
    chk("merr imem_err", 64'(imem_err), 64'd1);
    chk("merr valP", valP, 64'h7FFE);
    chk("merr icode", 64'(icode), 64'd4);
    chk("merr rA/rB", 64'({rA, rB}), 64'h12);
    handshake(0, 1'b0, 64'd0, 0);

    // randomized instruction stream
    do_reset();
    fixed_delay = -1;
    wait_valid(cyc);
    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      nxt = ERR_LO - 64'($urandom_range(1, 10));
      else if (sel == 1) nxt = 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7));
      else if (sel <= 3) nxt = expi.valp;
      else               nxt = 64'h1000 + 64'($urandom_range(0, 4095));
      sel = $urandom_range(0, 19);
      if (sel == 0)      ic = 4'h0;
      else if (sel == 1) ic = 4'hC + 4'($urandom_range(0, 3));
      else               ic = 4'($urandom_range(1, 11));
      put_instr(nxt, ic);
      handshake($urandom_range(0, 2), 1'($urandom), nxt, $urandom_range(0, 2));
      if (exp_halted) do_reset();
      wait_valid(cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
